ofs_user_irq_sched: RTL

- Shares one MSI-X-style interrupt write channel among `NUM_IRQ` AFU user-interrupt sources.
- Each source's request is edge-detected, held in a pending bit and granted round-robin.
- Each grant is issued as one address/data write transaction: source i uses address `ADDR_BASE + i*ADDR_STRIDE` and data `DATA_BASE + i`.
- Sits between the AFU user-IRQ wires and the PCIe interrupt/write path of the port.

---
 rtl/ofs_user_irq_pkg.sv | 23 ++
 rtl/ofs_rr_pick.sv | 33 +++
 rtl/ofs_user_irq_sched.sv | 104 ++++++++++
 3 files changed

// File: rtl/ofs_user_irq_pkg.sv
// Shared types and address helpers for the user-interrupt scheduler.
package ofs_user_irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        ISSUE
    } irq_sched_state_e;

    localparam logic [63:0] DEF_ADDR_BASE   = 64'h20000;
    localparam logic [63:0] DEF_ADDR_STRIDE = 64'h1000;
    localparam logic [31:0] DEF_DATA_BASE   = 32'hbeef_0000;

    // Write address of source idx: base + idx*stride.
    function automatic logic [63:0] irq_addr(
        input int unsigned idx,
        input logic [63:0] base   = DEF_ADDR_BASE,
        input logic [63:0] stride = DEF_ADDR_STRIDE
    );
        return base + 64'(idx) * stride;
    endfunction

endpackage

// File: rtl/ofs_rr_pick.sv
// Combinational round-robin pick: first request at or after last+1 (mod N).
module ofs_rr_pick #(
    parameter int N     = 7,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int                 cand_i;
        logic [IDX_W-1:0]   cand;
        gnt    = '0;
        idx    = '0;
        valid  = 1'b0;
        cand_i = 0;
        cand   = '0;
        // Offsets 1..N walk the ring starting just past the last winner.
        for (int off = 1; off <= N; off++) begin
            cand_i = (int'(last) + off) % N;
            cand   = IDX_W'(cand_i);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ofs_user_irq_sched.sv
// Round-robin scheduler sharing one interrupt write channel among user IRQ sources.
// Optional OFS_USER_IRQ_PBA_EN: masked rises stay pending and the pending port is exposed.
module ofs_user_irq_sched
    import ofs_user_irq_pkg::*;
#(
    parameter int                NUM_IRQ     = 7,
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = ADDR_W'(DEF_ADDR_BASE),
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(DEF_ADDR_STRIDE),
    parameter logic [DATA_W-1:0] DATA_BASE   = DATA_W'(DEF_DATA_BASE),
    parameter int                IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] usr_irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [ADDR_W-1:0]  tx_addr,
    output logic [DATA_W-1:0]  tx_data,
    output logic [IDX_W-1:0]   tx_src,
`ifdef OFS_USER_IRQ_PBA_EN
    output logic [NUM_IRQ-1:0] pending,
`endif
    output logic [15:0]        irq_count
);

    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_IRQ - 1);

    irq_sched_state_e   state, state_n;
    logic [NUM_IRQ-1:0] irq_q, pend, pend_n, rise, elig, clr, pick_gnt;
    logic [IDX_W-1:0]   last_grant, pick_idx;
    logic               pick_valid, any_elig, load, accept;

    assign rise     = usr_irq & ~irq_q;
    assign elig     = pend & ~irq_mask;
    assign any_elig = |elig;
    assign tx_valid = (state == ISSUE);
    assign accept   = tx_valid & tx_ready;
    assign clr      = load ? pick_gnt : '0;

    ofs_rr_pick #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (elig),
        .last  (last_grant),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A rise landing on the cycle its bit is cleared wins, so no edge is lost.
`ifdef OFS_USER_IRQ_PBA_EN
    assign pend_n  = (pend & ~clr) | rise;
    assign pending = pend;
`else
    assign pend_n  = ((pend & ~clr) | rise) & ~irq_mask;
`endif

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE:  if (any_elig) state_n = ARB;
            ARB: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: if (tx_ready) state_n = any_elig ? ARB : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_q      <= '0;
            pend       <= '0;
            last_grant <= LAST_INIT;
            tx_addr    <= '0;
            tx_data    <= '0;
            tx_src     <= '0;
            irq_count  <= '0;
        end else begin
            state <= state_n;
            irq_q <= usr_irq;
            pend  <= pend_n;
            if (load) begin
                tx_addr    <= ADDR_W'(irq_addr(32'(pick_idx), 64'(ADDR_BASE), 64'(ADDR_STRIDE)));
                tx_data    <= DATA_BASE + DATA_W'(pick_idx);
                tx_src     <= pick_idx;
                last_grant <= pick_idx;
            end
            if (accept && irq_count != 16'hFFFF) irq_count <= irq_count + 16'd1;
        end
    end

endmodule
